// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: WIDTH-bit, DEPTH-stage register pipeline with per-stage
// valid bits, valid/ready handshake at both ends, bubble collapsing and a
// synchronous flush. Data leaves in exact acceptance order.
//
// Ports:
//   clk        clock, rising edge
//   rstn       synchronous active-low reset (priority over flush/handshake)
//   flush      synchronous clear of all valid bits; data registers hold
//   in_valid   producer has data on in_data
//   in_data    producer data
//   in_ready   pipeline accepts in_data this cycle (independent of in_valid)
//   out_valid  last stage holds valid data
//   out_data   data of last stage
//   out_ready  consumer takes out_data this cycle
//   count      number of valid stages, 0..DEPTH
module pipe_reg_chain #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_free;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_v_nxt;
  logic [WIDTH-1:0] w_d_nxt [DEPTH];
  logic             w_pop;
  logic             w_push;

  always_comb begin
    w_adv   = '0;
    w_free  = '0;
    w_load  = '0;
    w_v_nxt = r_v;
    w_d_nxt = r_d;

    w_pop            = r_v[DEPTH-1] & out_ready;
    w_adv[DEPTH-1]   = w_pop;
    w_free[DEPTH-1]  = ~r_v[DEPTH-1] | w_pop;

    // Free/advance chain resolved from the output back toward the input, so
    // a pop ripples combinationally all the way to in_ready.
    for (int unsigned j = 1; j < DEPTH; j++) begin
      w_adv[DEPTH-1-j]  = r_v[DEPTH-1-j] & w_free[DEPTH-j];
      w_free[DEPTH-1-j] = ~r_v[DEPTH-1-j] | w_adv[DEPTH-1-j];
    end

    in_ready = ~flush & w_free[0];
    w_push   = in_valid & in_ready;

    w_load[0] = w_push;
    for (int unsigned j = 1; j < DEPTH; j++) begin
      w_load[j] = w_adv[j-1];
    end

    // A stage that advances without reload keeps its stale data but drops v.
    for (int unsigned j = 0; j < DEPTH; j++) begin
      w_v_nxt[j] = w_load[j] | (r_v[j] & ~w_adv[j]);
    end

    if (w_load[0]) begin
      w_d_nxt[0] = in_data;
    end
    for (int unsigned j = 1; j < DEPTH; j++) begin
      if (w_load[j]) begin
        w_d_nxt[j] = r_d[j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_v     <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_d[i] <= RESET_VAL;
      end
    end else if (flush) begin
      r_v     <= '0;
      r_count <= '0;
    end else begin
      r_v     <= w_v_nxt;
      r_d     <= w_d_nxt;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed self-checking bench for pipe_reg_chain with
// WIDTH=8, DEPTH=4, RESET_VAL=8'hA5. Covers reset, streaming, backpressure
// fill, bubble collapse, flush and mid-stream reset.
module tb_pipe_reg_chain;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  pipe_reg_chain #(
    .WIDTH    (8),
    .DEPTH    (4),
    .RESET_VAL(8'hA5)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic c_rdy(input string tag, input logic exp);
    checks++;
    assert (in_ready === exp) else begin
      errors++;
      $error("FAIL %s in_ready got=%0b exp=%0b", tag, in_ready, exp);
    end
  endtask

  task automatic c_vld(input string tag, input logic exp);
    checks++;
    assert (out_valid === exp) else begin
      errors++;
      $error("FAIL %s out_valid got=%0b exp=%0b", tag, out_valid, exp);
    end
  endtask

  task automatic c_dat(input string tag, input logic [7:0] exp);
    checks++;
    assert (out_data === exp) else begin
      errors++;
      $error("FAIL %s out_data got=%0h exp=%0h", tag, out_data, exp);
    end
  endtask

  task automatic c_cnt(input string tag, input logic [2:0] exp);
    checks++;
    assert (count === exp) else begin
      errors++;
      $error("FAIL %s count got=%0d exp=%0d", tag, count, exp);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset for two edges
    tick();
    tick();
    rstn = 1'b1;
    #1;
    c_vld("reset", 1'b0);
    c_dat("reset", 8'hA5);
    c_cnt("reset", 3'd0);
    c_rdy("reset", 1'b1);

    // Streaming 01..10 with out_ready=1
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      in_data = 8'(e);
      #1;
      c_rdy("stream", 1'b1);
      tick();
      c_vld("stream", (e >= 4));
      c_cnt("stream", (e >= 4) ? 3'd4 : 3'(e));
      if (e >= 4) c_dat("stream", 8'(e - 3));
    end
    in_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      c_vld("drain", (j <= 3));
      c_cnt("drain", 3'(4 - j));
      c_dat("drain", (j <= 3) ? 8'(13 + j) : 8'h10);
    end

    // Backpressure fill
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(8'h11 + k);
      #1;
      c_rdy("fill", 1'b1);
      tick();
      c_cnt("fill", 3'(k + 1));
    end
    c_vld("fill", 1'b1);
    c_dat("fill", 8'h11);
    in_data = 8'h15;
    for (int k = 0; k < 2; k++) begin
      #1;
      c_rdy("full", 1'b0);
      tick();
      c_cnt("full", 3'd4);
      c_dat("full", 8'h11);
    end
    out_ready = 1'b1;
    #1;
    c_rdy("full_pop", 1'b1);
    tick();
    c_cnt("full_pop", 3'd4);
    c_vld("full_pop", 1'b1);
    c_dat("full_pop", 8'h12);
    out_ready = 1'b0;
    in_data   = 8'h16;
    #1;
    c_rdy("full_again", 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      c_vld("bp_drain", 1'b1);
      c_dat("bp_drain", 8'(8'h12 + j));
      c_cnt("bp_drain", 3'(4 - j));
    end
    tick();
    c_vld("bp_empty", 1'b0);
    c_cnt("bp_empty", 3'd0);

    // Bubble collapse with out_ready=0
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h21;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1;
    in_data  = 8'h22;
    tick();
    in_valid = 1'b0;
    c_cnt("bubble", 3'd2);
    c_vld("bubble", 1'b1);
    c_dat("bubble", 8'h21);
    tick();
    tick();
    c_cnt("bubble_hold", 3'd2);
    c_dat("bubble_hold", 8'h21);
    out_ready = 1'b1;
    tick();
    c_vld("bubble_2nd", 1'b1);
    c_dat("bubble_2nd", 8'h22);
    c_cnt("bubble_2nd", 3'd1);
    tick();
    c_vld("bubble_empty", 1'b0);
    c_cnt("bubble_empty", 3'd0);

    // Flush with three entries
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'h30 + k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    c_cnt("pre_flush", 3'd3);
    c_vld("pre_flush", 1'b1);
    c_dat("pre_flush", 8'h30);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    #1;
    c_rdy("flush", 1'b0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    c_cnt("flush", 3'd0);
    c_vld("flush", 1'b0);
    c_dat("flush", 8'h30);
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      c_vld("post_flush", 1'b0);
      c_cnt("post_flush", 3'd0);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h34;
    #1;
    c_rdy("post_flush_push", 1'b1);
    tick();
    in_valid = 1'b0;
    c_cnt("post_flush_push", 3'd1);
    tick();
    tick();
    c_vld("post_flush_lat", 1'b0);
    tick();
    c_vld("post_flush_out", 1'b1);
    c_dat("post_flush_out", 8'h34);
    c_cnt("post_flush_out", 3'd1);
    out_ready = 1'b1;
    tick();
    c_vld("post_flush_pop", 1'b0);
    c_cnt("post_flush_pop", 3'd0);

    // Reset mid-stream
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 8'(8'h41 + k);
      tick();
    end
    c_cnt("pre_rst", 3'd4);
    c_dat("pre_rst", 8'h43);
    rstn    = 1'b0;
    in_data = 8'h47;
    tick();
    rstn = 1'b1;
    c_cnt("mid_rst", 3'd0);
    c_vld("mid_rst", 1'b0);
    c_dat("mid_rst", 8'hA5);
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(8'h51 + k);
      tick();
      c_vld("rst_stream", (k == 3));
      c_cnt("rst_stream", 3'(k + 1));
    end
    c_dat("rst_stream", 8'h51);
    in_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      c_vld("rst_drain", 1'b1);
      c_dat("rst_drain", 8'(8'h51 + j));
      c_cnt("rst_drain", 3'(4 - j));
    end
    tick();
    c_vld("rst_empty", 1'b0);
    c_cnt("rst_empty", 3'd0);
    c_dat("rst_empty", 8'h54);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
